// File: rtl/ysyx_25050147_ctrl_pkg.sv
// Shared definitions for the single-cycle-issue control FSM and its decoder.
//
// Contents:
//   ctrl_state_e  - control FSM state encoding
//   OP_*          - decoder op_type class codes (5 bits)
//   next_pc()     - sequential fetch address (wraps modulo 2^32)
package ysyx_25050147_ctrl_pkg;

  localparam int OP_W = 5;

  localparam logic [OP_W-1:0] OP_ILLEGAL = 5'd0;
  localparam logic [OP_W-1:0] OP_ADDI    = 5'd1;
  localparam logic [OP_W-1:0] OP_EBREAK  = 5'd2;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_WAIT   = 3'd1,
    ST_DECODE = 3'd2,
    ST_WB     = 3'd3,
    ST_HALT   = 3'd4,
    ST_ERR    = 3'd5
  } ctrl_state_e;

  // Plain 32-bit add: 32'hFFFF_FFFC + 4 naturally wraps to 0.
  function automatic logic [31:0] next_pc(input logic [31:0] cur);
    return cur + 32'd4;
  endfunction

endpackage

// File: rtl/ysyx_25050147_ctrl.sv
// Multi-cycle instruction control FSM: FETCH -> WAIT -> DECODE -> WB, with
// absorbing HALT (ebreak) and ERR (illegal op or fetch timeout) states.
//
// Ports:
//   clk         in   clock, all state changes on rising edge
//   rst         in   synchronous active-high reset
//   ifu_req     out  one-cycle fetch request (FETCH state)
//   ifu_addr    out  fetch address, equal to pc
//   ifu_ack     in   fetch data valid (only honoured in WAIT)
//   ifu_rdata   in   fetched instruction word
//   inst        out  latched instruction, feeds the decoder
//   op_type     in   decoder class: 0 illegal, 1 addi, 2 ebreak
//   rf_wen      out  register-file write enable (WB state only)
//   pc          out  current program counter
//   halt        out  high while in HALT
//   err         out  high while in ERR
//   retire_cnt  out  retired instruction count (wraps)
//
// Handshake: ifu_req is a single-cycle pulse; the fetch unit answers with
// ifu_ack (data on ifu_rdata in the same cycle) any number of cycles later.
// An ack is only consumed in WAIT; acks seen in any other state are dropped.
module ysyx_25050147_ctrl
  import ysyx_25050147_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [7:0]  TIMEOUT  = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req,
  output logic [31:0] ifu_addr,
  input  logic        ifu_ack,
  input  logic [31:0] ifu_rdata,
  output logic [31:0] inst,
  input  logic [4:0]  op_type,
  output logic        rf_wen,
  output logic [31:0] pc,
  output logic        halt,
  output logic        err,
  output logic [31:0] retire_cnt
);

  ctrl_state_e state;
  ctrl_state_e state_next;
  logic [7:0]  wait_cnt;
  logic        timeout_hit;

  // The current WAIT cycle is the TIMEOUT-th one without an ack. Widened
  // compare so TIMEOUT=0 or 255 cannot overflow the check.
  assign timeout_hit = ({1'b0, wait_cnt} + 9'd1) >= {1'b0, TIMEOUT};

  always_comb begin
    state_next = state;
    case (state)
      ST_FETCH:  state_next = ST_WAIT;
      ST_WAIT: begin
        // Ack has priority over a timeout landing in the same cycle.
        if (ifu_ack)          state_next = ST_DECODE;
        else if (timeout_hit) state_next = ST_ERR;
      end
      ST_DECODE: begin
        case (op_type)
          OP_ADDI:   state_next = ST_WB;
          OP_EBREAK: state_next = ST_HALT;
          default:   state_next = ST_ERR;
        endcase
      end
      ST_WB:     state_next = ST_FETCH;
      ST_HALT:   state_next = ST_HALT;
      ST_ERR:    state_next = ST_ERR;
      default:   state_next = ST_ERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_FETCH;
      pc         <= RESET_PC;
      inst       <= 32'd0;
      retire_cnt <= 32'd0;
      wait_cnt   <= 8'd0;
    end else begin
      state <= state_next;

      // Counter is zero whenever we are outside WAIT, so every entry into
      // WAIT starts from a clean count.
      if (state == ST_WAIT) begin
        wait_cnt <= wait_cnt + 8'd1;
        if (ifu_ack) inst <= ifu_rdata;
      end else begin
        wait_cnt <= 8'd0;
      end

      if (state == ST_WB) begin
        pc         <= next_pc(pc);
        retire_cnt <= retire_cnt + 32'd1;
      end else if (state == ST_DECODE && state_next == ST_HALT) begin
        // ebreak retires on entry to HALT; pc stays on the ebreak.
        retire_cnt <= retire_cnt + 32'd1;
      end
    end
  end

  // Pulses are masked by rst so nothing escapes during a reset cycle, and
  // the first request appears in the first cycle with rst low.
  assign ifu_req  = (state == ST_FETCH) && !rst;
  assign rf_wen   = (state == ST_WB) && !rst;
  assign ifu_addr = pc;
  assign halt     = (state == ST_HALT);
  assign err      = (state == ST_ERR);

endmodule

// File: tb/tb_ysyx_25050147_ctrl.sv
// Directed bench for ysyx_25050147_ctrl. The bench plays the fetch unit and
// the decoder. A second instance with RESET_PC=32'hFFFF_FFFC shares all
// inputs and exercises the pc wrap.
module tb_ysyx_25050147_ctrl;

  localparam logic [31:0] RPC   = 32'h8000_0000;
  localparam logic [31:0] RPC_W = 32'hFFFF_FFFC;
  localparam logic [4:0]  OP_IDLE = 5'h1F;

  logic        clk;
  logic        rst;
  logic        ifu_ack;
  logic [31:0] ifu_rdata;
  logic [4:0]  op_type;

  logic        ifu_req, rf_wen, halt, err;
  logic [31:0] ifu_addr, inst, pc, retire_cnt;
  logic        ifu_req_w, rf_wen_w, halt_w, err_w;
  logic [31:0] ifu_addr_w, inst_w, pc_w, retire_cnt_w;

  int total = 0;
  int bad   = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  ysyx_25050147_ctrl dut (
    .clk(clk), .rst(rst), .ifu_req(ifu_req), .ifu_addr(ifu_addr),
    .ifu_ack(ifu_ack), .ifu_rdata(ifu_rdata), .inst(inst), .op_type(op_type),
    .rf_wen(rf_wen), .pc(pc), .halt(halt), .err(err), .retire_cnt(retire_cnt)
  );

  ysyx_25050147_ctrl #(.RESET_PC(RPC_W)) dut_w (
    .clk(clk), .rst(rst), .ifu_req(ifu_req_w), .ifu_addr(ifu_addr_w),
    .ifu_ack(ifu_ack), .ifu_rdata(ifu_rdata), .inst(inst_w), .op_type(op_type),
    .rf_wen(rf_wen_w), .pc(pc_w), .halt(halt_w), .err(err_w),
    .retire_cnt(retire_cnt_w)
  );

  // ---------------- event monitor ----------------
  int          rf_cnt = 0;
  int          req_cnt = 0;
  logic [31:0] last_addr_w = 32'd0;

  always @(posedge clk) begin
    if (rf_wen)    rf_cnt  = rf_cnt + 1;
    if (ifu_req)   req_cnt = req_cnt + 1;
    if (ifu_req_w) last_addr_w = ifu_addr_w;
  end

  // ---------------- scoreboard helper ----------------
  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at a negedge with rst still high and checks reset state.
  task automatic do_reset(input string tag);
    rst = 1'b1; ifu_ack = 1'b0; op_type = OP_IDLE; ifu_rdata = 32'hDEAD_BEEF;
    tick(); tick();
    @(negedge clk);
    check({tag, " rst pc"},      pc,         RPC);
    check({tag, " rst pc_w"},    pc_w,       RPC_W);
    check({tag, " rst inst"},    inst,       32'd0);
    check({tag, " rst retire"},  retire_cnt, 32'd0);
    check({tag, " rst halt"},    {31'd0, halt},    32'd0);
    check({tag, " rst err"},     {31'd0, err},     32'd0);
    check({tag, " rst rf_wen"},  {31'd0, rf_wen},  32'd0);
    check({tag, " rst ifu_req"}, {31'd0, ifu_req}, 32'd0);
  endtask

  typedef struct {
    logic [31:0] word;
    int          delay;        // WAIT cycles without ack before the ack
    logic        ack_in_fetch; // spurious ack during FETCH
    logic [4:0]  op;
    int          exp_rf;
    logic [31:0] exp_pc_delta;
    logic [31:0] exp_retire;
    logic        exp_halt;
    logic        exp_err;
    int          exp_req;      // requests after DECODE
  } vec_t;

  vec_t vecs[7];

  initial begin
    int rf0, req0, waits;
    logic seen;

    vecs[0] = '{32'h0010_0093,   0, 1'b0, 5'd1,  1, 32'd4, 32'd1, 1'b0, 1'b0, 1};
    vecs[1] = '{32'h00A0_0113,  10, 1'b0, 5'd1,  1, 32'd4, 32'd1, 1'b0, 1'b0, 1};
    vecs[2] = '{32'h0010_0073,   0, 1'b1, 5'd2,  0, 32'd0, 32'd1, 1'b1, 1'b0, 0};
    vecs[3] = '{32'hFFFF_FFFF,   3, 1'b0, 5'd0,  0, 32'd0, 32'd0, 1'b0, 1'b1, 0};
    vecs[4] = '{32'h1234_5678,   0, 1'b0, 5'd3,  0, 32'd0, 32'd0, 1'b0, 1'b1, 0};
    vecs[5] = '{32'h0000_0000,   1, 1'b1, 5'd31, 0, 32'd0, 32'd0, 1'b0, 1'b1, 0};
    // Ack on the 255th WAIT cycle: ack wins over the coinciding timeout.
    vecs[6] = '{32'h0010_8093, 254, 1'b0, 5'd1,  1, 32'd4, 32'd1, 1'b0, 1'b0, 1};

    // ---------------- table-driven single instructions ----------------
    for (int r = 0; r < 7; r++) begin
      string t;
      t = $sformatf("row%0d", r);
      do_reset(t);
      tick();
      rst = 1'b0; ifu_ack = vecs[r].ack_in_fetch; ifu_rdata = 32'h0BAD_0BAD;
      @(negedge clk);
      check({t, " fetch req"},  {31'd0, ifu_req}, 32'd1);
      check({t, " fetch addr"}, ifu_addr, RPC);
      tick();
      for (int i = 0; i < vecs[r].delay; i++) begin
        ifu_ack = 1'b0; ifu_rdata = $urandom; tick();
      end
      ifu_ack = 1'b1; ifu_rdata = vecs[r].word; tick();
      ifu_ack = 1'b0; ifu_rdata = $urandom; op_type = vecs[r].op;
      @(negedge clk);
      rf0 = rf_cnt; req0 = req_cnt;
      tick();
      op_type = OP_IDLE;
      repeat (3) tick();
      @(negedge clk);
      check({t, " inst"},   inst, vecs[r].word);
      check({t, " rf_wen"}, 32'(rf_cnt - rf0), 32'(vecs[r].exp_rf));
      check({t, " pc"},     pc,   RPC + vecs[r].exp_pc_delta);
      check({t, " pc_w"},   pc_w, RPC_W + vecs[r].exp_pc_delta);
      check({t, " addr_w"}, last_addr_w, RPC_W + vecs[r].exp_pc_delta);
      check({t, " retire"}, retire_cnt, vecs[r].exp_retire);
      check({t, " halt"},   {31'd0, halt}, {31'd0, vecs[r].exp_halt});
      check({t, " err"},    {31'd0, err},  {31'd0, vecs[r].exp_err});
      check({t, " req"},    32'(req_cnt - req0), 32'(vecs[r].exp_req));
    end

    // ---------------- addi then ebreak, zero-wait, cycle exact ----------------
    do_reset("prog");
    for (int c = 1; c <= 10; c++) begin
      tick();
      rst = 1'b0;
      ifu_ack = (c == 2 || c == 6);
      ifu_rdata = (c == 2) ? 32'h0010_0093 : (c == 6) ? 32'h0010_0073 : $urandom;
      op_type = (c == 3) ? 5'd1 : (c == 7) ? 5'd2 : OP_IDLE;
      @(negedge clk);
      check($sformatf("prog c%0d rf_wen", c), {31'd0, rf_wen}, {31'd0, c == 4});
      check($sformatf("prog c%0d halt", c),   {31'd0, halt},   {31'd0, c >= 8});
      check($sformatf("prog c%0d ifu_req", c), {31'd0, ifu_req},
            {31'd0, c == 1 || c == 5});
    end
    check("prog retire", retire_cnt, 32'd2);
    check("prog pc",     pc,         32'h8000_0004);
    check("prog inst",   inst,       32'h0010_0073);
    check("prog pc_w",   pc_w,       32'h0000_0000);

    // ---------------- fetch timeout ----------------
    do_reset("tmo");
    tick(); rst = 1'b0;
    @(negedge clk);
    rf0 = rf_cnt;
    tick();
    waits = 0; seen = 1'b0;
    for (int c = 0; c < 400; c++) begin
      ifu_rdata = $urandom;
      @(negedge clk);
      if (err) begin seen = 1'b1; break; end
      waits++;
      tick();
    end
    check("tmo err seen", {31'd0, seen}, 32'd1);
    check("tmo waits",    32'(waits), 32'd255);
    check("tmo rf_wen",   32'(rf_cnt - rf0), 32'd0);
    check("tmo retire",   retire_cnt, 32'd0);
    check("tmo pc",       pc, RPC);

    // ---------------- reset mid-WAIT, stale ack afterwards ----------------
    do_reset("mid");
    tick(); rst = 1'b0;
    tick(); tick();
    tick(); rst = 1'b1;
    @(negedge clk);
    check("mid rst ifu_req", {31'd0, ifu_req}, 32'd0);
    check("mid rst rf_wen",  {31'd0, rf_wen},  32'd0);
    tick(); rst = 1'b0; ifu_ack = 1'b1; ifu_rdata = 32'hBAAD_F00D;
    @(negedge clk);
    check("mid fresh req",  {31'd0, ifu_req}, 32'd1);
    check("mid fresh addr", ifu_addr, RPC);
    tick(); ifu_ack = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("mid inst", inst, 32'd0);
    check("mid pc",   pc,   RPC);
    check("mid err",  {31'd0, err}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_25050147_ctrl.md
YSYX_25050147_CTRL -- requirements
Module: ysyx_25050147_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter TIMEOUT, default 8'd255, meaning the maximum number of WAIT cycles before fetch error.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port ifu_req, output, 1 bit: fetch request pulse.
REQ-006 SHALL have port ifu_addr, output, 32 bits: fetch address, equal to pc.
REQ-007 SHALL have port ifu_ack, input, 1 bit: fetch data valid.
REQ-008 SHALL have port ifu_rdata, input, 32 bits: fetched instruction word.
REQ-009 SHALL have port inst, output, 32 bits: latched instruction, driven to the decoder's instruction input.
REQ-010 SHALL have port op_type, input, 5 bits: decoder class; 0 illegal, 1 addi, 2 ebreak.
REQ-011 SHALL have port rf_wen, output, 1 bit: register-file write enable.
REQ-012 SHALL have port pc, output, 32 bits: current program counter.
REQ-013 SHALL have port halt, output, 1 bit: sticky ebreak halt flag.
REQ-014 SHALL have port err, output, 1 bit: sticky illegal-instruction or fetch-timeout flag.
REQ-015 SHALL have port retire_cnt, output, 32 bits: count of retired instructions.

Function
REQ-016 SHALL implement the FSM states FETCH, WAIT, DECODE, WB, HALT and ERR.
REQ-017 FETCH SHALL assert ifu_req for exactly one cycle, then go to WAIT unconditionally; ifu_ack seen during FETCH SHALL be ignored.
REQ-018 WAIT SHALL, on ifu_ack=1, latch ifu_rdata into inst and go to DECODE; ifu_req SHALL be 0 in WAIT.
REQ-019 WAIT SHALL count cycles without ack; when the count reaches TIMEOUT with ifu_ack=0 it SHALL go to ERR; ack and timeout in the same cycle SHALL resolve as ack.
REQ-020 The timeout counter SHALL clear on every entry to WAIT.
REQ-021 DECODE SHALL sample op_type: 1 goes to WB, 2 goes to HALT, and any other value goes to ERR.
REQ-022 WB SHALL assert rf_wen for exactly one cycle, update pc to pc+4 (mod 2^32, so 32'hFFFF_FFFC wraps to 0), increment retire_cnt, and go to FETCH.
REQ-023 rf_wen SHALL be 0 in every state except WB.
REQ-024 Entry to HALT SHALL increment retire_cnt once and leave pc unchanged.
REQ-025 HALT and ERR SHALL be absorbing until rst.
REQ-026 halt SHALL equal (state==HALT) and err SHALL equal (state==ERR); halt and err SHALL never both be 1.
REQ-027 inst SHALL hold its value outside the WAIT ack cycle.
REQ-028 retire_cnt SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-029 Minimum latency per addi SHALL be 4 cycles (FETCH, WAIT with ack, DECODE, WB).

Reset
REQ-030 rst=1 at a rising edge SHALL force state=FETCH, pc=RESET_PC, inst=0, retire_cnt=0, timeout counter=0, halt=0, err=0, rf_wen=0 and ifu_req=0 in that cycle, from any state including mid-WAIT.
REQ-031 ifu_req SHALL first assert in the first cycle with rst=0.
REQ-032 An ifu_ack arriving after rst for a pre-reset request SHALL be ignored if it occurs in FETCH.

Structure
REQ-033 The state encoding and the op_type codes (OP_ILLEGAL=0, OP_ADDI=1, OP_EBREAK=2) SHALL live in a shared package used by both the decoder and this block.
REQ-034 The block SHALL be a single module with no sub-modules; pc, inst, retire_cnt and the timeout counter SHALL be local registers.

Verification
REQ-035 Zero-wait ack, program of addi then ebreak: the bench SHALL see rf_wen high once at cycle 4, halt=1 from cycle 8, retire_cnt=2, and pc=32'h8000_0004.
REQ-036 Ack delayed 10 cycles for one addi: the bench SHALL see rf_wen exactly once, pc advanced by 4, and err=0.
REQ-037 No ack for 255 WAIT cycles: the bench SHALL see err=1, rf_wen never asserted, and retire_cnt=0.
REQ-038 op_type=0 in DECODE: the bench SHALL see err=1, pc unchanged, and no further ifu_req.
REQ-039 rst asserted mid-WAIT with ack arriving in the next cycle: the bench SHALL see the ack ignored, pc=RESET_PC, and a fresh ifu_req in the first cycle after rst is released.
REQ-040 RESET_PC=32'hFFFF_FFFC with one addi: the bench SHALL see pc wrap to 32'h0000_0000 and the next ifu_addr equal to 0.
